// File: rtl/pool2_pkg.sv
// Shared types and derived-size helpers for the Pool2 stream controller.
// The optional POOL2_STALL_EN feature lives in the top and its address generator.
package pool2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } pool2_state_e;

    function automatic int calc_ifm_size_next(input int ifm_size);
        return ifm_size / 2;
    endfunction

    function automatic int calc_num_passes(input int ifm_depth, input int number_of_units);
        return (ifm_depth + number_of_units - 1) / number_of_units;
    endfunction

endpackage

// File: rtl/pool2_addr_gen.sv
// Row / column-pair / pass counters and IFM read-address generation for Pool2.
// With POOL2_STALL_EN the top drives hold from its stall port; otherwise hold is tied low.
module pool2_addr_gen
    import pool2_pkg::*;
#(
    parameter int IFM_SIZE   = 14,
    parameter int NUM_PASSES = 1,
    parameter int ADDR_W     = 8,
    parameter int PASS_W     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic              advance,
    input  logic              hold,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [PASS_W-1:0] pass_sel,
    output logic              row_odd,
    output logic              last_issue
);

    localparam int HALF  = IFM_SIZE / 2;
    localparam int COL_W = $clog2(HALF) + 1;
    localparam int ROW_W = $clog2(IFM_SIZE) + 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(HALF - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IFM_SIZE - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [PASS_W-1:0] pass;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] addr_hold;
    logic [PASS_W-1:0] pass_hold;
    logic [ADDR_W-1:0] cur_addr;
    logic              col_last;
    logic              row_last;
    logic              pass_last;

    assign col_last   = (col == COL_LAST);
    assign row_last   = (row == ROW_LAST);
    assign pass_last  = (pass == PASS_LAST);
    assign last_issue = col_last && row_last && pass_last;
    assign row_odd    = row[0];

    // During a stall the previously issued address is re-presented, so the RAM
    // output still carries the push that is parked in the first delay stage.
    assign cur_addr = hold ? addr_hold : addr_cnt;
    assign addr_a   = active ? cur_addr : '0;
    assign addr_b   = active ? cur_addr + ADDR_W'(1) : '0;
    assign pass_sel = hold ? pass_hold : pass;

    // Column pairs are row-major with no gaps, so the even-column address is a
    // plain step-by-two counter that only resets at the pass wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            col       <= '0;
            row       <= '0;
            pass      <= '0;
            addr_cnt  <= '0;
            addr_hold <= '0;
            pass_hold <= '0;
        end else begin
            if (!hold) begin
                addr_hold <= addr_cnt;
                pass_hold <= pass;
            end
            if (advance) begin
                if (col_last) begin
                    col <= '0;
                    if (row_last) begin
                        row      <= '0;
                        addr_cnt <= '0;
                        pass     <= pass_last ? '0 : pass + PASS_W'(1);
                    end else begin
                        row      <= row + ROW_W'(1);
                        addr_cnt <= addr_cnt + ADDR_W'(2);
                    end
                end else begin
                    col      <= col + COL_W'(1);
                    addr_cnt <= addr_cnt + ADDR_W'(2);
                end
            end
        end
    end

endmodule

// File: rtl/pool2_stream_ctrl.sv
// Pool2 producer/sequencer: streams IFM pixel pairs into the pool units and writes pooled results.
// Optional macro POOL2_STALL_EN adds a stall input that freezes counters and strobe delay line.
module pool2_stream_ctrl
    import pool2_pkg::*;
#(
    parameter int DATA_WIDTH            = 32,
    parameter int IFM_SIZE              = 14,
    parameter int IFM_DEPTH             = 3,
    parameter int NUMBER_OF_UNITS       = 3,
    parameter int POOL_LATENCY          = 1,
    parameter int IFM_SIZE_NEXT         = calc_ifm_size_next(IFM_SIZE),
    parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
    parameter int NUM_PASSES            = calc_num_passes(IFM_DEPTH, NUMBER_OF_UNITS)
) (
    input  logic                             clk,
    input  logic                             reset,
`ifdef POOL2_STALL_EN
    input  logic                             stall,
`endif
    input  logic                             start,
    output logic [ADDRESS_SIZE_IFM-1:0]      ifm_addr_A,
    output logic [ADDRESS_SIZE_IFM-1:0]      ifm_addr_B,
    input  logic [DATA_WIDTH-1:0]            ifm_data_A,
    input  logic [DATA_WIDTH-1:0]            ifm_data_B,
    output logic [$clog2(NUM_PASSES):0]      pass_sel,
    output logic [DATA_WIDTH-1:0]            data_out_A,
    output logic [DATA_WIDTH-1:0]            data_out_B,
    output logic                             fifo_enable,
    output logic                             pool_enable,
    output logic                             ofm_we,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_addr,
    output logic                             busy,
    output logic                             done,
    output pool2_state_e                     state_dbg
);

    localparam int PASS_W = $clog2(NUM_PASSES) + 1;
    localparam logic [ADDRESS_SIZE_NEXT_IFM-1:0] OFM_LAST =
        ADDRESS_SIZE_NEXT_IFM'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1);

    pool2_state_e state;
    pool2_state_e state_nx;

    logic hold;
    logic issue;
    logic row_odd;
    logic last_issue;

    // Strobes are valid-only: each of fifo_enable, pool_enable and ofm_we
    // qualifies its data for exactly the cycle it is high. There is no ready;
    // the only backpressure is stall, which freezes everything in place.
    logic                    fifo_v;
    logic                    fifo_odd;
    logic                    fifo_last;
    logic [POOL_LATENCY:0]   pool_v;
    logic [POOL_LATENCY:0]   pool_last;
    logic                    done_q;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_cnt;

`ifdef POOL2_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign issue = (state == READ) && !hold;

    pool2_addr_gen #(
        .IFM_SIZE   (IFM_SIZE),
        .NUM_PASSES (NUM_PASSES),
        .ADDR_W     (ADDRESS_SIZE_IFM),
        .PASS_W     (PASS_W)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .active     (state == READ),
        .advance    (issue),
        .hold       (hold),
        .addr_a     (ifm_addr_A),
        .addr_b     (ifm_addr_B),
        .pass_sel   (pass_sel),
        .row_odd    (row_odd),
        .last_issue (last_issue)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = READ;
            READ:    if (issue && last_issue) state_nx = DRAIN;
            DRAIN:   if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Delay line: stage fifo_v is the RAM-data cycle, pool_v[0] the window
    // completion, pool_v[POOL_LATENCY] the write; a last-push flag rides along.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            fifo_v    <= 1'b0;
            fifo_odd  <= 1'b0;
            fifo_last <= 1'b0;
            pool_v    <= '0;
            pool_last <= '0;
            done_q    <= 1'b0;
            ofm_cnt   <= '0;
        end else begin
            state <= state_nx;
            if (!hold) begin
                fifo_v       <= issue;
                fifo_odd     <= row_odd;
                fifo_last    <= issue && last_issue;
                pool_v[0]    <= fifo_v && fifo_odd;
                pool_last[0] <= fifo_v && fifo_last;
                for (int i = 1; i <= POOL_LATENCY; i++) begin
                    pool_v[i]    <= pool_v[i-1];
                    pool_last[i] <= pool_last[i-1];
                end
                done_q <= pool_v[POOL_LATENCY] && pool_last[POOL_LATENCY];
                if (pool_v[POOL_LATENCY]) begin
                    ofm_cnt <= (ofm_cnt == OFM_LAST) ? '0 : ofm_cnt + ADDRESS_SIZE_NEXT_IFM'(1);
                end
            end
        end
    end

    assign fifo_enable = fifo_v && !hold;
    assign pool_enable = pool_v[0] && !hold;
    assign ofm_we      = pool_v[POOL_LATENCY] && !hold;
    assign done        = done_q && !hold;
    assign ofm_addr    = ofm_cnt;
    assign busy        = (state != IDLE);
    assign state_dbg   = state;
    assign data_out_A  = fifo_enable ? ifm_data_A : '0;
    assign data_out_B  = fifo_enable ? ifm_data_B : '0;

endmodule

// File: tb/tb_pool2_stream_ctrl.sv
// Self-checking bench for pool2_stream_ctrl: single-pass and two-pass instances,
// RAM models returning address-derived data, and a queue-based scoreboard of strobes.
module tb_pool2_stream_ctrl;
    import pool2_pkg::*;

    localparam int S    = 14;
    localparam int HALF = 7;
    localparam int NEXT = 7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset  = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
`ifdef POOL2_STALL_EN
    logic stall  = 1'b0;
`endif
    int   cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 0: defaults (1 pass) ----------------
    logic [7:0]  addr_a0, addr_b0;
    logic [31:0] ram_a0, ram_b0, dout_a0, dout_b0;
    logic [0:0]  ps0;
    logic        fifo0, pool0, we0, busy0, done0;
    logic [5:0]  oaddr0;
    pool2_state_e st0;

    pool2_stream_ctrl u_dut0 (
        .clk         (clk),
        .reset       (reset),
`ifdef POOL2_STALL_EN
        .stall       (stall),
`endif
        .start       (start0),
        .ifm_addr_A  (addr_a0),
        .ifm_addr_B  (addr_b0),
        .ifm_data_A  (ram_a0),
        .ifm_data_B  (ram_b0),
        .pass_sel    (ps0),
        .data_out_A  (dout_a0),
        .data_out_B  (dout_b0),
        .fifo_enable (fifo0),
        .pool_enable (pool0),
        .ofm_we      (we0),
        .ofm_addr    (oaddr0),
        .busy        (busy0),
        .done        (done0),
        .state_dbg   (st0)
    );

    // ---------------- DUT 1: IFM_DEPTH=6 (2 passes) ----------------
    logic [7:0]  addr_a1, addr_b1;
    logic [31:0] ram_a1, ram_b1, dout_a1, dout_b1;
    logic [1:0]  ps1;
    logic        fifo1, pool1, we1, busy1, done1;
    logic [5:0]  oaddr1;
    pool2_state_e st1;

    pool2_stream_ctrl #(.IFM_DEPTH(6), .NUMBER_OF_UNITS(3)) u_dut1 (
        .clk         (clk),
        .reset       (reset),
`ifdef POOL2_STALL_EN
        .stall       (1'b0),
`endif
        .start       (start1),
        .ifm_addr_A  (addr_a1),
        .ifm_addr_B  (addr_b1),
        .ifm_data_A  (ram_a1),
        .ifm_data_B  (ram_b1),
        .pass_sel    (ps1),
        .data_out_A  (dout_a1),
        .data_out_B  (dout_b1),
        .fifo_enable (fifo1),
        .pool_enable (pool1),
        .ofm_we      (we1),
        .ofm_addr    (oaddr1),
        .busy        (busy1),
        .done        (done1),
        .state_dbg   (st1)
    );

    // RAM models: 1-cycle latency, data = address (+256 per map-group bank)
    always @(posedge clk) begin
        ram_a0 <= 32'(addr_a0);
        ram_b0 <= 32'(addr_b0);
        ram_a1 <= 32'(addr_a1) + 32'(ps1) * 256;
        ram_b1 <= 32'(addr_b1) + 32'(ps1) * 256;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    logic [63:0] exp_fifo_q[$];   // {cycle, data_out_A}
    logic [31:0] exp_pool_q[$];   // cycle
    logic [63:0] exp_we_q[$];     // {cycle, ofm_addr}
    int          exp_done;
    int          done_cnt;
    int          we_cnt;
    bit          mon_en  = 1'b0;
    int          mon_sel = 0;
    logic [63:0] mon_e;
    logic [31:0] mon_p;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int shift_t(input int e, input int st_at, input int st_len);
        return (e >= st_at) ? e + st_len : e;
    endfunction

    task automatic load_expect(input int t0, input int npass, input int st_at, input int st_len);
        int k;
        for (int p = 0; p < npass; p++) begin
            for (int r = 0; r < S; r++) begin
                for (int c = 0; c < HALF; c++) begin
                    k = (p * S + r) * HALF + c;
                    exp_fifo_q.push_back({32'(shift_t(t0 + k + 1, st_at, st_len)),
                                          32'(p * 256 + r * S + 2 * c)});
                    if (r % 2 == 1) begin
                        exp_pool_q.push_back(32'(shift_t(t0 + k + 2, st_at, st_len)));
                        exp_we_q.push_back({32'(shift_t(t0 + k + 3, st_at, st_len)),
                                            32'((r / 2) * NEXT + c)});
                    end
                end
            end
        end
        exp_done = shift_t(t0 + npass * S * HALF + 3, st_at, st_len);
    endtask

    logic        m_fifo, m_pool, m_we, m_done;
    logic [31:0] m_a, m_b, m_oaddr;
    always_comb begin
        m_fifo  = (mon_sel == 0) ? fifo0 : fifo1;
        m_pool  = (mon_sel == 0) ? pool0 : pool1;
        m_we    = (mon_sel == 0) ? we0 : we1;
        m_done  = (mon_sel == 0) ? done0 : done1;
        m_a     = (mon_sel == 0) ? dout_a0 : dout_a1;
        m_b     = (mon_sel == 0) ? dout_b0 : dout_b1;
        m_oaddr = (mon_sel == 0) ? 32'(oaddr0) : 32'(oaddr1);
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (m_fifo) begin
                if (exp_fifo_q.size() == 0) check("fifo_extra", 1, 0);
                else begin
                    mon_e = exp_fifo_q.pop_front();
                    check("fifo_cyc", cyc, mon_e[63:32]);
                    check("data_a", m_a, mon_e[31:0]);
                    check("data_b", m_b, mon_e[31:0] + 1);
                end
            end
            if (m_pool) begin
                if (exp_pool_q.size() == 0) check("pool_extra", 1, 0);
                else begin
                    mon_p = exp_pool_q.pop_front();
                    check("pool_cyc", cyc, mon_p);
                end
            end
            if (m_we) begin
                we_cnt++;
                if (exp_we_q.size() == 0) check("we_extra", 1, 0);
                else begin
                    mon_e = exp_we_q.pop_front();
                    check("we_cyc", cyc, mon_e[63:32]);
                    check("ofm_addr", m_oaddr, mon_e[31:0]);
                end
            end
            if (m_done) begin
                done_cnt++;
                check("done_cyc", cyc, exp_done);
                check("done_we_apart", m_we, 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_case(input int sel, input int npass, input int st_len, input bit busy_start);
        int t0;
        exp_fifo_q.delete();
        exp_pool_q.delete();
        exp_we_q.delete();
        done_cnt = 0;
        we_cnt   = 0;
        mon_sel  = sel;
        @(posedge clk); #1;
        if (sel == 0) start0 = 1'b1;
        else          start1 = 1'b1;
        t0 = cyc + 1;
        load_expect(t0, npass, t0 + 20, st_len);
        mon_en = 1'b1;
        while (cyc < exp_done + 4) begin
            @(posedge clk); #1;
            start0 = (sel == 0) && busy_start && (cyc == t0 + 50);
            start1 = 1'b0;
`ifdef POOL2_STALL_EN
            stall = (st_len > 0) && (cyc >= t0 + 20) && (cyc < t0 + 20 + st_len);
`endif
        end
        @(negedge clk);
        mon_en = 1'b0;
        check("fifo_left", exp_fifo_q.size(), 0);
        check("pool_left", exp_pool_q.size(), 0);
        check("we_left", exp_we_q.size(), 0);
        check("done_cnt", done_cnt, 1);
        check("we_cnt", we_cnt, npass * 49);
        check("busy_end", (sel == 0) ? busy0 : busy1, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_addr_a"}, 32'(addr_a0), 0);
        check({tag, "_addr_b"}, 32'(addr_b0), 0);
        check({tag, "_strobes"}, {fifo0, pool0, we0, done0}, 0);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_ofm_addr"}, 32'(oaddr0), 0);
        check({tag, "_dout"}, dout_a0 | dout_b0, 0);
        check({tag, "_pass"}, 32'(ps0) + 32'(ps1), 0);
        check({tag, "_state"}, 32'(st0), 32'(IDLE));
    endtask

    task automatic reset_mid_read();
        int t0;
        @(posedge clk); #1;
        start0 = 1'b1;
        t0 = cyc + 1;
        @(posedge clk); #1;
        start0 = 1'b0;
        while (cyc < t0 + 30) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("pre_rst_busy", busy0, 1);
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            check_zero_outputs("mid_rst");
        end
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("post_rst_quiet", {fifo0, pool0, we0, busy0}, 0);
            @(posedge clk);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("init_rst");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);

        reset_mid_read();
        run_case(0, 1, 0, 1'b1);
        run_case(1, 2, 0, 1'b0);
`ifdef POOL2_STALL_EN
        run_case(0, 1, 3, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete (checks %0d, errors %0d)", checks, errors);
        $fatal(1);
    end

endmodule
